// File: rtl/framebuffer_line_fetcher_if.sv
// rtl/framebuffer_line_fetcher_if.sv - RGB pixel type and PSRAM burst bus interface
//
// rgb_s        : 8-bit-per-channel pixel handed to the RGB->YUV stage.
// burst_bus_if : PSRAM controller command/read-data port.
//   master drives cmd_en, cmd, addr, wr_data, data_mask;
//   slave drives ready, rd_data, rd_data_valid; clk is shared.

package framebuffer_line_fetcher_pkg;
   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_s;
endpackage

interface burst_bus_if (
   input logic clk
);
   logic        ready;
   logic        cmd_en;
   logic        cmd;
   logic [20:0] addr;
   logic [63:0] wr_data;
   logic [7:0]  data_mask;
   logic [63:0] rd_data;
   logic        rd_data_valid;

   modport master (
      input  clk, ready, rd_data, rd_data_valid,
      output cmd_en, cmd, addr, wr_data, data_mask
   );

   modport slave (
      input  clk, cmd_en, cmd, addr, wr_data, data_mask,
      output ready, rd_data, rd_data_valid
   );
endinterface

// File: rtl/framebuffer_line_fetcher.sv
// rtl/framebuffer_line_fetcher.sv - fetch one RGB332 scanline from PSRAM and stream it as pixels
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   mem                     : burst_bus_if master (read-only PSRAM port)
//   line_start, line_addr   : start-of-line pulse and byte address of the line
//   pixel, pixel_valid      : expanded pixel and its valid flag
//   pixel_ready             : consumer accepts the current pixel
//   underflow               : sticky, consumer wanted a pixel that was not there
//   busy                    : line still being fetched or a burst outstanding

module framebuffer_line_fetcher
   import framebuffer_line_fetcher_pkg::*;
#(
   parameter int BURST_WORDS = 4,
   parameter int FIFO_WORDS  = 16,
   parameter int LINE_PIXELS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   burst_bus_if.master mem,
   input  logic        line_start,
   input  logic [20:0] line_addr,
   output rgb_s        pixel,
   output logic        pixel_valid,
   input  logic        pixel_ready,
   output logic        underflow,
   output logic        busy
);
   localparam int N_CMDS = LINE_PIXELS / (8 * BURST_WORDS);
   localparam int CMD_W  = $clog2(N_CMDS + 1);
   localparam int BEAT_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
   localparam int AW     = $clog2(FIFO_WORDS);
   localparam int PW     = AW + 1;
   localparam int PIX_W  = $clog2(LINE_PIXELS + 1);
   localparam logic [20:0] ADDR_STEP = 21'(8 * BURST_WORDS);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA} state_t;
   state_t state, state_d;

   logic [20:0]       cur_addr, issue_addr, addr_q;
   logic [CMD_W-1:0]  cmds_left;
   logic [BEAT_W-1:0] beat_cnt;
   logic              discard, cmd_en_q, issue, underflow_q;
   logic [63:0]       fifo_mem [FIFO_WORDS];
   logic [PW-1:0]     wr_ptr, rd_ptr, fifo_count;
   logic [63:0]       sh_word;
   logic [3:0]        sh_cnt;
   logic [PIX_W-1:0]  pix_count;
   logic [7:0]        p;
   logic              space_ok, last_beat, accept, push, pop;

   assign fifo_count  = wr_ptr - rd_ptr;
   assign space_ok    = fifo_count <= PW'(FIFO_WORDS - BURST_WORDS);
   assign last_beat   = mem.rd_data_valid && (beat_cnt == BEAT_W'(BURST_WORDS - 1));
   assign pixel_valid = (sh_cnt != 4'd0);
   assign accept      = pixel_valid && pixel_ready;
   // Beats of a burst issued for an abandoned line, or arriving with line_start, are dropped.
   assign push        = (state == WAIT_DATA) && mem.rd_data_valid && !discard && !line_start;
   // Reload the shifter when empty, or while its last byte leaves, so words stream back to back.
   assign pop         = (fifo_count != '0) && ((sh_cnt == 4'd0) || ((sh_cnt == 4'd1) && accept));

   assign mem.cmd_en    = cmd_en_q;
   assign mem.addr      = addr_q;
   assign mem.cmd       = 1'b0;
   assign mem.wr_data   = '0;
   assign mem.data_mask = '0;
   assign underflow     = underflow_q;
   assign busy          = (state != IDLE);

   // A new line flushes the FIFO, so it always has room: the first command is
   // issued on the line_start edge itself when the controller is ready.
   always_comb begin
      state_d    = state;
      issue      = 1'b0;
      issue_addr = cur_addr;
      case (state)
         IDLE, REQ: begin
            if (line_start) begin
               issue_addr = line_addr;
               if (mem.ready) begin
                  issue   = 1'b1;
                  state_d = WAIT_DATA;
               end else begin
                  state_d = REQ;
               end
            end else if ((state == REQ) && mem.ready && space_ok) begin
               issue   = 1'b1;
               state_d = WAIT_DATA;
            end
         end
         WAIT_DATA: begin
            if (last_beat) begin
               if (line_start || discard || (cmds_left != '0)) state_d = REQ;
               else                                              state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_en_q    <= 1'b0;
         addr_q      <= '0;
         cur_addr    <= '0;
         cmds_left   <= '0;
         beat_cnt    <= '0;
         discard     <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         sh_word     <= '0;
         sh_cnt      <= '0;
         // Starting at a full count means "no line in progress": no underflow before the first line.
         pix_count   <= PIX_W'(LINE_PIXELS);
         underflow_q <= 1'b0;
      end else begin
         cmd_en_q <= issue;
         if (issue) begin
            addr_q    <= issue_addr;
            cur_addr  <= issue_addr + ADDR_STEP;
            cmds_left <= line_start ? CMD_W'(N_CMDS - 1) : cmds_left - CMD_W'(1);
         end else if (line_start) begin
            cur_addr  <= line_addr;
            cmds_left <= CMD_W'(N_CMDS);
         end

         if ((state == WAIT_DATA) && mem.rd_data_valid)
            beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);

         if (state == WAIT_DATA) begin
            if (last_beat)       discard <= 1'b0;
            else if (line_start) discard <= 1'b1;
         end

         if (line_start) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            sh_word     <= '0;
            sh_cnt      <= '0;
            pix_count   <= '0;
            underflow_q <= 1'b0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
               rd_ptr  <= rd_ptr + PW'(1);
               sh_word <= fifo_mem[rd_ptr[AW-1:0]];
               sh_cnt  <= 4'd8;
            end else if (accept) begin
               sh_word <= {8'h00, sh_word[63:8]};
               sh_cnt  <= sh_cnt - 4'd1;
            end
            if (accept) pix_count <= pix_count + PIX_W'(1);
            if (pixel_ready && !pixel_valid && (pix_count < PIX_W'(LINE_PIXELS)))
               underflow_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= mem.rd_data;
   end

   always_comb begin
      p       = sh_word[7:0];
      pixel.r = {p[7:5], p[7:5], p[7:6]};
      pixel.g = {p[4:2], p[4:2], p[4:3]};
      pixel.b = {p[1:0], p[1:0], p[1:0], p[1:0]};
   end
endmodule
